// File: rtl/dec_pkg.sv
// Shared definitions for the decoder/scanner block: FSM state encoding,
// mode constants and the dwell counter sizing helper.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of a counter that must hold 0..dwell-1; never narrower than 1 bit.
    function automatic int dwell_cnt_width(input int dwell);
        if (dwell <= 1) begin
            return 1;
        end else begin
            return $clog2(dwell);
        end
    endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable; all zeros when disabled.
module dec_onehot #(
    parameter int N = 2
) (
    input  logic [N-1:0]        sel,
    input  logic                en,
    output logic [(1<<N)-1:0]   y
);

    // Raise exactly the selected bit when enabled, otherwise drive all zeros.
    always_comb begin
        y = {(1<<N){1'b0}};
        if (en) begin
            y[sel] = 1'b1;
        end else begin
            y = {(1<<N){1'b0}};
        end
    end

endmodule

// File: rtl/dec_scan.sv
// One-hot decoder with a direct-select mode and a self-advancing scan mode.
// All outputs come straight from flops; the next one-hot value is decoded
// from the next index so y always matches idx in the same cycle.
module dec_scan #(
    parameter int N     = 2,
    parameter int DWELL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        sel,
    input  logic                load,
    output logic [(1<<N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    import dec_pkg::*;

    localparam int             CW       = dwell_cnt_width(DWELL);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]   IDX_LAST = {N{1'b1}};

    dec_state_t             state_r;
    dec_state_t             state_next;
    logic [(1<<N)-1:0]      y_r;
    logic [(1<<N)-1:0]      y_next;
    logic [N-1:0]           idx_r;
    logic [N-1:0]           idx_next;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_next;
    logic                   wrap_r;
    logic                   wrap_next;

    // Next-state and datapath: idle holds index and dwell, direct follows sel,
    // scan loads (with priority) or advances after DWELL cycles.
    always_comb begin
        state_next = IDLE;
        idx_next   = idx_r;
        cnt_next   = cnt_r;
        wrap_next  = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else if (mode == MODE_DIRECT) begin
            state_next = DIRECT;
            idx_next   = sel;
        end else begin
            state_next = SCAN;
            if (load) begin
                idx_next = sel;
                cnt_next = {CW{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                idx_next  = idx_r + N'(1);
                cnt_next  = {CW{1'b0}};
                wrap_next = (idx_r == IDX_LAST);
            end else begin
                cnt_next = cnt_r + CW'(1);
            end
        end
    end

    dec_onehot #(
        .N (N)
    ) u_onehot (
        .sel (idx_next),
        .en  (en),
        .y   (y_next)
    );

    // State and output registers; an illegal state encoding falls back to a
    // cleared IDLE just like reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            y_r     <= {(1<<N){1'b0}};
            idx_r   <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DIRECT, SCAN: begin
                    state_r <= state_next;
                    y_r     <= y_next;
                    idx_r   <= idx_next;
                    cnt_r   <= cnt_next;
                    wrap_r  <= wrap_next;
                end
                default: begin
                    state_r <= IDLE;
                    y_r     <= {(1<<N){1'b0}};
                    idx_r   <= {N{1'b0}};
                    cnt_r   <= {CW{1'b0}};
                    wrap_r  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_r;
    assign idx  = idx_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_dec_scan.sv
// Directed self-checking bench for dec_scan: a N=2/DWELL=2 instance for the
// main scenarios and a N=3/DWELL=1 instance for the mid-scan reset case.
module tb_dec_scan;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=2, DWELL=2
    logic       rst_a = 1'b0, en_a = 1'b0, mode_a = 1'b0, load_a = 1'b0;
    logic [1:0] sel_a = 2'd0;
    logic [3:0] y_a;
    logic [1:0] idx_a;
    logic       wrap_a;

    // Instance B: N=3, DWELL=1
    logic       rst_b = 1'b0, en_b = 1'b0, mode_b = 1'b0, load_b = 1'b0;
    logic [2:0] sel_b = 3'd0;
    logic [7:0] y_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    int checks = 0;
    int errors = 0;

    dec_scan #(.N(2), .DWELL(2)) dut_a (
        .clk (clk), .rst (rst_a), .en (en_a), .mode (mode_a),
        .sel (sel_a), .load (load_a), .y (y_a), .idx (idx_a), .wrap (wrap_a)
    );

    dec_scan #(.N(3), .DWELL(1)) dut_b (
        .clk (clk), .rst (rst_b), .en (en_b), .mode (mode_b),
        .sel (sel_b), .load (load_b), .y (y_b), .idx (idx_b), .wrap (wrap_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        en_a = 1'b1; mode_a = 1'b1;
        tick();
        tick();
        checks++; if (y_a !== 4'b0000) begin errors++; $display("FAIL reset_y got=%b exp=0000", y_a); end
        checks++; if (idx_a !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap_a); end
        checks++; if (y_b !== 8'h00) begin errors++; $display("FAIL reset_y_b got=%b exp=00000000", y_b); end
        rst_a = 1'b0; rst_b = 1'b0;
        en_a = 1'b0; mode_a = 1'b0;
    endtask

    task automatic test_direct();
        logic [3:0] exp_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        en_a = 1'b1; mode_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel_a  = 2'(i);
            load_a = (i == 1) ? 1'b1 : 1'b0;
            tick();
            checks++; if (y_a !== exp_y[i]) begin errors++; $display("FAIL direct_y[%0d] got=%b exp=%b", i, y_a, exp_y[i]); end
            checks++; if (idx_a !== 2'(i)) begin errors++; $display("FAIL direct_idx[%0d] got=%0d exp=%0d", i, idx_a, i); end
        end
        // Idle: outputs clear, index holds, load/sel ignored
        en_a = 1'b0; load_a = 1'b1; sel_a = 2'd0;
        tick();
        checks++; if (y_a !== 4'b0000) begin errors++; $display("FAIL idle_y got=%b exp=0000", y_a); end
        checks++; if (idx_a !== 2'd3) begin errors++; $display("FAIL idle_idx got=%0d exp=3", idx_a); end
        load_a = 1'b0;
    endtask

    task automatic test_scan_wrap();
        logic [1:0] exp_idx [6] = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
        logic       exp_wr  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] ey;
        en_a = 1'b1; mode_a = 1'b1; load_a = 1'b1; sel_a = 2'd2;
        tick();
        checks++; if (idx_a !== 2'd2) begin errors++; $display("FAIL scan_load_idx got=%0d exp=2", idx_a); end
        checks++; if (y_a !== 4'b0100) begin errors++; $display("FAIL scan_load_y got=%b exp=0100", y_a); end
        load_a = 1'b0; sel_a = 2'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ey = 4'b0001 << exp_idx[i];
            checks++; if (idx_a !== exp_idx[i]) begin errors++; $display("FAIL scan_idx[%0d] got=%0d exp=%0d", i, idx_a, exp_idx[i]); end
            checks++; if (y_a !== ey) begin errors++; $display("FAIL scan_y[%0d] got=%b exp=%b", i, y_a, ey); end
            checks++; if (wrap_a !== exp_wr[i]) begin errors++; $display("FAIL scan_wrap[%0d] got=%b exp=%b", i, wrap_a, exp_wr[i]); end
        end
    endtask

    task automatic test_load_priority();
        // idx=1 with dwell=0; one more cycle makes the advance due
        tick();
        checks++; if (idx_a !== 2'd1) begin errors++; $display("FAIL prio_pre_idx got=%0d exp=1", idx_a); end
        load_a = 1'b1; sel_a = 2'd3;
        tick();
        checks++; if (idx_a !== 2'd3) begin errors++; $display("FAIL prio_idx got=%0d exp=3", idx_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL prio_wrap got=%b exp=0", wrap_a); end
        load_a = 1'b0; sel_a = 2'd0;
        tick();
        checks++; if (idx_a !== 2'd3) begin errors++; $display("FAIL prio_dwell_idx got=%0d exp=3", idx_a); end
        tick();
        checks++; if (idx_a !== 2'd0) begin errors++; $display("FAIL prio_adv_idx got=%0d exp=0", idx_a); end
        checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL prio_adv_wrap got=%b exp=1", wrap_a); end
    endtask

    task automatic test_pause_mode_change();
        // From idx=0,dwell=0 reach idx=1 with dwell=1
        tick(); tick(); tick();
        checks++; if (idx_a !== 2'd1) begin errors++; $display("FAIL pause_pre_idx got=%0d exp=1", idx_a); end
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (y_a !== 4'b0000) begin errors++; $display("FAIL pause_y[%0d] got=%b exp=0000", i, y_a); end
            checks++; if (idx_a !== 2'd1) begin errors++; $display("FAIL pause_idx[%0d] got=%0d exp=1", i, idx_a); end
        end
        en_a = 1'b1;
        tick();
        checks++; if (idx_a !== 2'd2) begin errors++; $display("FAIL resume_idx got=%0d exp=2", idx_a); end
        checks++; if (y_a !== 4'b0100) begin errors++; $display("FAIL resume_y got=%b exp=0100", y_a); end
        mode_a = 1'b0; sel_a = 2'd0;
        tick();
        checks++; if (y_a !== 4'b0001) begin errors++; $display("FAIL mode_chg_y got=%b exp=0001", y_a); end
        checks++; if (idx_a !== 2'd0) begin errors++; $display("FAIL mode_chg_idx got=%0d exp=0", idx_a); end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] ey;
        en_b = 1'b1; mode_b = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (idx_b !== 3'd5) begin errors++; $display("FAIL midscan_idx got=%0d exp=5", idx_b); end
        checks++; if (y_b !== 8'b0010_0000) begin errors++; $display("FAIL midscan_y got=%b exp=00100000", y_b); end
        rst_b = 1'b1; load_b = 1'b1; sel_b = 3'd6;
        tick();
        checks++; if (y_b !== 8'h00) begin errors++; $display("FAIL midrst_y got=%b exp=00000000", y_b); end
        checks++; if (idx_b !== 3'd0) begin errors++; $display("FAIL midrst_idx got=%0d exp=0", idx_b); end
        checks++; if (wrap_b !== 1'b0) begin errors++; $display("FAIL midrst_wrap got=%b exp=0", wrap_b); end
        rst_b = 1'b0; load_b = 1'b0; sel_b = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            ey = 8'b0000_0001 << (i % 8);
            checks++; if (idx_b !== 3'(i % 8)) begin errors++; $display("FAIL rescan_idx[%0d] got=%0d exp=%0d", i, idx_b, i % 8); end
            checks++; if (y_b !== ey) begin errors++; $display("FAIL rescan_y[%0d] got=%b exp=%b", i, y_b, ey); end
            checks++; if (wrap_b !== ((i == 8) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL rescan_wrap[%0d] got=%b", i, wrap_b); end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_wrap();
        test_load_priority();
        test_pause_mode_change();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
